// File: rtl/dpcm_decoder.sv
// dpcm_decoder: reconstructs clamped samples by accumulating signed differences into a predictor
module dpcm_decoder #(
  parameter int WIDTH     = 8,
  parameter int SAT_MAX   = 200,
  parameter int PRED_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Clear,
  output logic             Ready,
  output logic [WIDTH-1:0] DataOut,
  output logic             Done,
  output logic [15:0]      Count
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [WIDTH-1:0] SAT_V  = SAT_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_V = PRED_INIT[WIDTH-1:0];
  state_t state_q, state_d;
  logic [WIDTH-1:0] diff_q, diff_d, pred_q, pred_d, data_out_q, data_out_d;
  logic done_q, done_d;
  logic [15:0] count_q, count_d;
  logic signed [WIDTH+1:0] sum;
  logic [WIDTH-1:0] result;
  logic finish;
  // predictor plus sign-extended difference, clamped to the pixel range
  always_comb begin
    sum    = signed'({2'b00, pred_q}) + signed'({{2{diff_q[WIDTH-1]}}, diff_q});
    result = sum[WIDTH+1] ? '0 : (sum > signed'({2'b00, SAT_V})) ? SAT_V : sum[WIDTH-1:0];
  end
  // handshake sequencing; Clear overrides only the predictor and counter
  always_comb begin
    finish     = state_q == HOLD && !Valid;
    state_d    = state_q == IDLE ? (Valid ? HOLD : IDLE) : (Valid ? HOLD : IDLE);
    diff_d     = state_q == IDLE && Valid ? DataIn : diff_q;
    data_out_d = finish ? result : data_out_q;
    done_d     = finish;
    pred_d     = Clear ? INIT_V : finish ? result : pred_q;
    count_d    = Clear ? 16'd0 : finish ? count_q + 16'd1 : count_q;
  end
  // state register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      diff_q     <= '0;
      pred_q     <= INIT_V;
      data_out_q <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      diff_q     <= diff_d;
      pred_q     <= pred_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end
  assign Ready   = state_q == IDLE;
  assign DataOut = data_out_q;
  assign Done    = done_q;
  assign Count   = count_q;
endmodule

// File: tb/tb_dpcm_decoder.sv
// tb_dpcm_decoder: directed and randomized checks against an arithmetic predictor model
module tb_dpcm_decoder;
  logic clk = 0, rst = 0, Valid = 0, Clear = 0;
  logic [7:0] DataIn = 0;
  logic Ready, Done;
  logic [7:0] DataOut;
  logic [15:0] Count;
  int total = 0, passed = 0;
  int m_pred = 0, m_out = 0, m_count = 0;

  dpcm_decoder dut (.clk(clk), .rst(rst), .Valid(Valid), .DataIn(DataIn), .Clear(Clear),
                    .Ready(Ready), .DataOut(DataOut), .Done(Done), .Count(Count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input int rdy, input int dn);
    chk({tag, ".Ready"}, 32'(Ready), rdy);
    chk({tag, ".Done"}, 32'(Done), dn);
    chk({tag, ".DataOut"}, 32'(DataOut), m_out);
    chk({tag, ".Count"}, 32'(Count), m_count);
  endtask

  // one transaction: diff d, Valid held for 'hold' edges, Clear optionally on the completing edge
  task automatic send(input int d, input int hold, input bit clr);
    int s;
    @(negedge clk);
    Valid = 1; DataIn = 8'(d);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold.Ready", 32'(Ready), 0);
      chk("hold.Done", 32'(Done), 0);
      @(negedge clk);
      DataIn = 8'(d + 2 * (i + 1));
    end
    Valid = 0; Clear = clr;
    @(posedge clk); #1;
    s = m_pred + d;
    m_out = s < 0 ? 0 : s > 200 ? 200 : s;
    m_pred = clr ? 0 : m_out;
    m_count = clr ? 0 : (m_count + 1) & 16'hFFFF;
    check_all("done", 1, 1);
    @(negedge clk);
    Clear = 0;
    @(posedge clk); #1;
    chk("after.Done", 32'(Done), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1; #1;
    check_all("reset_async", 1, 0);
    #2 rst = 0;
    repeat (5) @(posedge clk);
    #1 check_all("reset_idle", 1, 0);
    send(50, 1, 0);  chk("nom1", 32'(DataOut), 50);
    send(100, 1, 0); chk("nom2", 32'(DataOut), 150);
    send(30, 1, 0);  chk("nom3", 32'(DataOut), 180);
    chk("nom_count", 32'(Count), 3);
    send(100, 1, 0); chk("clamp_hi", 32'(DataOut), 200);
    send(-1, 1, 0);  chk("after_hi", 32'(DataOut), 199);
    send(-128, 1, 0);
    send(-61, 1, 0); chk("reach10", 32'(DataOut), 10);
    send(-128, 1, 0); chk("clamp_lo", 32'(DataOut), 0);
    send(5, 1, 0);   chk("after_lo", 32'(DataOut), 5);
    send(7, 4, 0);   chk("held", 32'(DataOut), 12);
    send(127, 1, 0);
    send(11, 1, 0);  chk("reach150", 32'(DataOut), 150);
    send(20, 1, 1);  chk("clr_out", 32'(DataOut), 170);
    chk("clr_count", 32'(Count), 0);
    send(20, 1, 0);  chk("clr_next", 32'(DataOut), 20);
    // Clear alone while idle
    @(negedge clk); Clear = 1;
    @(negedge clk); Clear = 0;
    m_pred = 0; m_count = 0;
    #6 check_all("clear_idle", 1, 0);
    send(33, 1, 0);  chk("clear_idle_next", 32'(DataOut), 33);
    // reset while a diff is captured but unfinished
    @(negedge clk); Valid = 1; DataIn = 8'd90;
    @(posedge clk); #2 rst = 1; #1;
    m_pred = 0; m_out = 0; m_count = 0;
    check_all("reset_hold", 1, 0);
    @(negedge clk); rst = 0; Valid = 0;
    @(posedge clk); #1 check_all("reset_hold_after", 1, 0);
    for (int i = 0; i < 60; i++)
      send($urandom_range(255) - 128, $urandom_range(3, 1), $urandom_range(7) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dpcm_decoder.md
# dpcm_decoder

DPCM reconstruction block for the DPCM datapath: accepts signed 8-bit difference samples over the Basic Valid/Ready handshake and adds each to a running predictor. The result is clamped to the pixel range [0, SAT_MAX] and presented on DataOut. It is the decode end of the DPCM chain and produces samples in the same 0..200 range the encode side saturates to.

## Interface
- WIDTH, 8: sample width in bits; DataIn and DataOut are both WIDTH bits.
- SAT_MAX, 200: upper clamp bound for reconstructed samples (unsigned, < 2^WIDTH).
- PRED_INIT, 0: predictor value after reset or Clear.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- Valid  in  1  producer strobe; DataIn is valid while high.
- DataIn  in  WIDTH  signed two's-complement difference (-128..127 for WIDTH=8).
- Clear  in  1  synchronous predictor/counter clear.
- Ready  out  1  block can accept a new difference.
- DataOut  out  WIDTH  last reconstructed sample (unsigned).
- Done  out  1  one-cycle pulse, high for one cycle after each DataOut update.
- Count  out  16  samples decoded since reset/Clear; wraps 0xFFFF -> 0.

## Operation
- Reset values: Ready=1, DataOut=0, Done=0, Count=0, predictor=PRED_INIT, state=IDLE, diff register=0.
- States:
  - IDLE (Ready=1): on a clock edge with Valid=1, capture DataIn into the diff register, drive Ready to 0 and go to HOLD.
  - HOLD (Ready=0): wait for Valid=0. On an edge with Valid=0, compute and register the result, set Done=1 and Ready=1, increment Count, and return to IDLE. While Valid stays 1, remain in HOLD; DataIn changes are ignored.
- Arithmetic:
  - sum = zero-extended predictor + sign-extended diff, computed in WIDTH+2 bits (signed).
  - If sum < 0, the result is 0.
  - If sum > SAT_MAX, the result is SAT_MAX.
  - Otherwise the result is sum[WIDTH-1:0].
  - The result is written to both DataOut and the predictor.
- Done is high only in the cycle after the completing edge; it is 0 in every other cycle.
- Clear applies at any edge where it is sampled high, in any state:
  - The predictor is set to PRED_INIT and Count to 0.
  - The state, Ready, the diff register and DataOut are unaffected.
  - If Clear coincides with a completing edge in HOLD, Clear wins for the predictor and Count: they become PRED_INIT and 0.
  - In that case DataOut still receives the result computed from the old predictor, and Done still pulses.
- Count increments with wrap; there is no saturation on Count.
- Asynchronous rst mid-operation: all outputs and state return to reset values immediately. A captured but unfinished diff is discarded with no Done.

## Timing
- Capture edge N (IDLE, Valid=1): Ready=0 from edge N.
- Completion edge M (first edge > N with Valid=0): DataOut, predictor, Count, Ready=1 and Done=1 all update at edge M. Done returns to 0 at edge M+1.
- Minimum transaction: Valid high for exactly one edge (N), low at N+1. The result and Ready=1 then appear at N+1, so the handshake period is 2 cycles.
- Producer rule: Valid must drop after Ready falls. If Valid is high at the first edge after Ready returns to 1, it is taken as a new sample.
- No combinational path from Valid or DataIn to any output; all outputs are registered.

## Test plan
- Reset: assert rst asynchronously mid-cycle. Outputs go immediately to Ready=1, DataOut=0, Done=0, Count=0; release, idle 5 cycles, and outputs are unchanged.
- Nominal decode: diffs +50, +100, +30 (one-cycle Valid pulses). DataOut is 50, 150, 180; Done pulses 3 times; Count ends at 3.
- Upper clamp: after 180, diff +100 gives DataOut=200 (not 280); then diff -1 gives 199.
- Lower clamp: reach predictor 10, then diff 0x80 (-128) gives DataOut=0; then diff +5 gives 5.
- Held Valid: Valid high for 4 edges with DataIn changing (+7, +9, +11, +13). Exactly one capture (+7) occurs and Ready stays 0 until Valid falls. The result is predictor+7 at the first Valid=0 edge.
- Clear priority: from predictor 150, assert Clear on the completing edge of diff +20. DataOut=170 and Done=1, but the predictor becomes 0 and Count=0. The next diff +20 gives 20.
